// File: rtl/regfile_4x_sb.sv
// Four-entry register bank fed by a one-hot write decoder, with two bypassing
// combinational read ports and a pending-write scoreboard driving a stall request.
module regfile_4x_sb #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 3,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       wr_onehot_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [1:0]       rd_addr_a_i,
    input  logic [1:0]       rd_addr_b_i,
    input  logic             rd_en_a_i,
    input  logic             rd_en_b_i,
    output logic [WIDTH-1:0] rd_data_a_o,
    output logic [WIDTH-1:0] rd_data_b_o,
    input  logic             issue_en_i,
    input  logic [1:0]       issue_addr_i,
    output logic [3:0]       pending_o,
    output logic             stall_o,
    output logic             onehot_err_o
);

    localparam logic [1:0] LP_ZERO_ADDR = 2'(ZERO_REG);
    localparam logic [3:0] LP_ZERO_MASK = 4'b0001 << ZERO_REG;

    // Zero or exactly one bit set.
    function automatic logic is_legal_sel(input logic [3:0] sel);
        return ((sel & (sel - 4'd1)) == 4'd0);
    endfunction

    logic [WIDTH-1:0] r_regs [4];
    logic [3:0]       r_pending;
    logic             r_err;

    logic             w_legal;
    logic [3:0]       w_wr_vec;
    logic [3:0]       w_issue_vec;
    logic [3:0]       w_pending_nxt;
    logic             w_pend_a;
    logic             w_pend_b;

    // Decode legal write and issue vectors; the zero register never takes part.
    always_comb begin
        w_legal     = is_legal_sel(wr_onehot_i);
        w_wr_vec    = 4'b0000;
        w_issue_vec = 4'b0000;
        if (w_legal) begin
            w_wr_vec = wr_onehot_i & ~LP_ZERO_MASK;
        end else begin
            w_wr_vec = 4'b0000;
        end
        if (issue_en_i) begin
            w_issue_vec = (4'b0001 << issue_addr_i) & ~LP_ZERO_MASK;
        end else begin
            w_issue_vec = 4'b0000;
        end
        // A same-cycle issue is the newer producer, so it wins over the clearing write.
        w_pending_nxt = (r_pending & ~w_wr_vec) | w_issue_vec;
    end

    // Register storage update.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int n = 0; n < 4; n++) begin
                r_regs[n] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_wr_vec[n]) begin
                    r_regs[n] <= wr_data_i;
                end
            end
        end
    end

    // Scoreboard and sticky multi-hot error flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pending <= 4'b0000;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_err     <= r_err | ((wr_onehot_i != 4'b0000) & ~w_legal);
        end
    end

    // Read ports with optional write-through bypass.
    always_comb begin
        rd_data_a_o = r_regs[rd_addr_a_i];
        rd_data_b_o = r_regs[rd_addr_b_i];
        if (rd_addr_a_i == LP_ZERO_ADDR) begin
            rd_data_a_o = {WIDTH{1'b0}};
        end else if (BYPASS && w_wr_vec[rd_addr_a_i]) begin
            rd_data_a_o = wr_data_i;
        end else begin
            rd_data_a_o = r_regs[rd_addr_a_i];
        end
        if (rd_addr_b_i == LP_ZERO_ADDR) begin
            rd_data_b_o = {WIDTH{1'b0}};
        end else if (BYPASS && w_wr_vec[rd_addr_b_i]) begin
            rd_data_b_o = wr_data_i;
        end else begin
            rd_data_b_o = r_regs[rd_addr_b_i];
        end
    end

    // Stall when a used source is pending and not satisfied by this cycle's write.
    always_comb begin
        w_pend_a = r_pending[rd_addr_a_i] & ~(BYPASS & w_wr_vec[rd_addr_a_i]);
        w_pend_b = r_pending[rd_addr_b_i] & ~(BYPASS & w_wr_vec[rd_addr_b_i]);
        stall_o  = (rd_en_a_i & w_pend_a) | (rd_en_b_i & w_pend_b);
    end

    assign pending_o    = r_pending;
    assign onehot_err_o = r_err;

endmodule

// File: tb/tb_regfile_4x_sb.sv
// Randomised scoreboard bench for regfile_4x_sb against an array-based reference model.
module tb_regfile_4x_sb;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [3:0]  wr_onehot_i;
    logic [63:0] wr_data_i;
    logic [1:0]  rd_addr_a_i, rd_addr_b_i;
    logic        rd_en_a_i, rd_en_b_i;
    logic [63:0] rd_data_a_o, rd_data_b_o;
    logic        issue_en_i;
    logic [1:0]  issue_addr_i;
    logic [3:0]  pending_o;
    logic        stall_o;
    logic        onehot_err_o;

    regfile_4x_sb #(.WIDTH(64), .ZERO_REG(3), .BYPASS(1'b1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .wr_onehot_i(wr_onehot_i), .wr_data_i(wr_data_i),
        .rd_addr_a_i(rd_addr_a_i), .rd_addr_b_i(rd_addr_b_i),
        .rd_en_a_i(rd_en_a_i), .rd_en_b_i(rd_en_b_i),
        .rd_data_a_o(rd_data_a_o), .rd_data_b_o(rd_data_b_o),
        .issue_en_i(issue_en_i), .issue_addr_i(issue_addr_i),
        .pending_o(pending_o), .stall_o(stall_o), .onehot_err_o(onehot_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        stall;
        logic [3:0]  pend;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_regs [4];
    bit          m_pend [4];
    bit          m_err;

    function automatic logic [63:0] m_read(input int addr, input logic [3:0] sel,
                                           input logic [63:0] wd);
        if (addr == 3) return 64'd0;
        if ($countones(sel) == 1 && sel[addr]) return wd;
        return m_regs[addr];
    endfunction

    function automatic bit m_pendx(input int addr, input logic [3:0] sel);
        bit written;
        written = ($countones(sel) == 1) && sel[addr] && (addr != 3);
        return m_pend[addr] && !written;
    endfunction

    task automatic drive(input bit rst, input logic [3:0] sel, input logic [63:0] wd,
                         input int ra, input int rb, input bit ea, input bit eb,
                         input bit ie, input int ia);
        exp_t e;
        int   widx;
        reset_i = rst; wr_onehot_i = sel; wr_data_i = wd;
        rd_addr_a_i = 2'(ra); rd_addr_b_i = 2'(rb);
        rd_en_a_i = ea; rd_en_b_i = eb; issue_en_i = ie; issue_addr_i = 2'(ia);
        e.a     = m_read(ra, sel, wd);
        e.b     = m_read(rb, sel, wd);
        e.stall = (ea && m_pendx(ra, sel)) || (eb && m_pendx(rb, sel));
        e.pend  = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
        e.err   = m_err;
        exp_q.push_back(e);
        @(posedge clk_i);
        if (rst) begin
            for (int n = 0; n < 4; n++) begin m_regs[n] = 64'd0; m_pend[n] = 1'b0; end
            m_err = 1'b0;
        end else begin
            widx = -1;
            for (int n = 0; n < 4; n++) if (sel[n]) widx = n;
            if ($countones(sel) > 1) m_err = 1'b1;
            else if (widx >= 0 && widx != 3) begin
                m_regs[widx] = wd;
                m_pend[widx] = 1'b0;
            end
            if (ie && ia != 3) m_pend[ia] = 1'b1;
        end
        #1;
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle
    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 5;
            if (rd_data_a_o !== e.a) begin errors++; $display("FAIL rd_a got %h exp %h t=%0t", rd_data_a_o, e.a, $time); end
            if (rd_data_b_o !== e.b) begin errors++; $display("FAIL rd_b got %h exp %h t=%0t", rd_data_b_o, e.b, $time); end
            if (stall_o !== e.stall) begin errors++; $display("FAIL stall got %b exp %b t=%0t", stall_o, e.stall, $time); end
            if (pending_o !== e.pend) begin errors++; $display("FAIL pending got %b exp %b t=%0t", pending_o, e.pend, $time); end
            if (onehot_err_o !== e.err) begin errors++; $display("FAIL onehot_err got %b exp %b t=%0t", onehot_err_o, e.err, $time); end
        end
    end

    initial begin
        logic [3:0] sel;
        int         r;
        reset_i = 1'b1; wr_onehot_i = 4'd0; wr_data_i = 64'd0;
        rd_addr_a_i = 2'd0; rd_addr_b_i = 2'd0; rd_en_a_i = 1'b0; rd_en_b_i = 1'b0;
        issue_en_i = 1'b0; issue_addr_i = 2'd0;
        repeat (2) @(posedge clk_i);
        #1;
        for (int n = 0; n < 4; n++) begin m_regs[n] = 64'd0; m_pend[n] = 1'b0; end
        m_err = 1'b0;

        // Reset state on all addresses
        drive(0, 4'b0000, 64'd0, 0, 1, 1, 1, 0, 0);
        drive(0, 4'b0000, 64'd0, 2, 3, 1, 1, 0, 0);
        // Bypass then stored value
        drive(0, 4'b0010, 64'hDEAD_BEEF, 1, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 64'd0, 1, 1, 0, 0, 0, 0);
        // Zero register writes and issues ignored
        drive(0, 4'b1000, 64'h5, 3, 3, 1, 1, 0, 0);
        drive(0, 4'b0000, 64'd0, 3, 3, 1, 1, 1, 3);
        drive(0, 4'b0000, 64'd0, 3, 1, 1, 1, 0, 0);
        // Issue, stall, writeback clears stall and pending
        drive(0, 4'b0000, 64'd0, 0, 0, 0, 0, 1, 2);
        drive(0, 4'b0000, 64'd0, 0, 2, 0, 1, 0, 0);
        drive(0, 4'b0100, 64'd7, 0, 2, 0, 1, 0, 0);
        drive(0, 4'b0000, 64'd0, 2, 2, 1, 1, 0, 0);
        // Same-cycle issue and write to a pending register
        drive(0, 4'b0000, 64'd0, 0, 0, 0, 0, 1, 0);
        drive(0, 4'b0001, 64'h11, 0, 0, 1, 1, 1, 0);
        drive(0, 4'b0000, 64'd0, 0, 0, 1, 0, 0, 0);
        // Multi-hot: no write, no bypass, sticky error
        drive(0, 4'b0011, 64'd9, 0, 1, 1, 1, 0, 0);
        drive(0, 4'b0000, 64'd0, 0, 1, 1, 1, 0, 0);
        drive(0, 4'b0000, 64'd0, 2, 3, 0, 0, 0, 0);
        drive(1, 4'b0010, 64'h77, 1, 0, 1, 1, 1, 1);
        drive(0, 4'b0000, 64'd0, 1, 0, 1, 1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) sel = 4'b0000;
            else if (r < 9) sel = 4'b0001 << $urandom_range(0, 3);
            else sel = 4'($urandom);
            drive(($urandom_range(0, 79) == 0), sel, {$urandom, $urandom},
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
        end

        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expectations exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_4x_sb.md
Name: regfile_4x_sb

Overview:
- Four-entry register bank with a pending-write scoreboard.
- Sits directly downstream of the 2:4 enabled write-address decoder: consumes its one-hot out_o vector as the write select.
- Provides two combinational read ports with write-through bypass, plus a stall signal for the issue logic when a source register still awaits writeback.

Parameters:
WIDTH, 64, data width of each register and of the read/write data ports
ZERO_REG, 3, index of the hardwired-zero register; reads return 0, writes and issues to it are ignored
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
wr_onehot_i  input  4  one-hot write select (decoder out_o); 4'b0000 = no write
wr_data_i  input  WIDTH  write data
rd_addr_a_i  input  2  read port A address
rd_addr_b_i  input  2  read port B address
rd_en_a_i  input  1  port A source is used this cycle (stall qualification only)
rd_en_b_i  input  1  port B source is used this cycle (stall qualification only)
rd_data_a_o  output  WIDTH  read port A data
rd_data_b_o  output  WIDTH  read port B data
issue_en_i  input  1  instruction issued that will later write issue_addr_i
issue_addr_i  input  2  destination register of the issued instruction
pending_o  output  4  registered scoreboard; bit n = register n awaits writeback
stall_o  output  1  combinational stall request
onehot_err_o  output  1  sticky flag: an illegal multi-hot write select was seen

Behaviour:
- One clock. Reset is synchronous and active-high; clock and reset ports are clk_i / reset_i.
- Reset (reset_i=1 at a rising edge):
  - all four registers cleared to 0;
  - pending_o = 4'b0000;
  - onehot_err_o = 0.
  - Reset overrides any simultaneous write or issue.
- Write select legality:
  - wr_onehot_i is legal iff it is zero or has exactly one bit set.
  - Legal, nonzero, not ZERO_REG: register n takes wr_data_i on the edge; pending_o[n] clears on the same edge.
  - Multi-hot: no register written, no pending bit cleared; onehot_err_o set on that edge and held until reset.
  - Write to ZERO_REG: no state change.
- Reads are combinational, zero latency.
  - rd_data_x_o = 0 when the address equals ZERO_REG.
  - Otherwise, with BYPASS=1 and a legal wr_onehot_i bit set for that address, the output equals wr_data_i.
  - Otherwise the output is the stored value.
  - Multi-hot selects are never bypassed.
- Scoreboard, per register n != ZERO_REG, next value of pending_o[n]:
  - issue (issue_en_i && issue_addr_i==n) → 1, even if a write clears n in the same cycle (the newer producer wins);
  - else legal write to n → 0;
  - else unchanged.
  - issue_addr_i==ZERO_REG is ignored; pending_o[ZERO_REG] is always 0.
- Stall:
  - stall_o = (rd_en_a_i && pend(rd_addr_a_i)) || (rd_en_b_i && pend(rd_addr_b_i)).
  - pend(x) = pending_o[x] && !(BYPASS && a legal write to x occurs this cycle).
  - stall_o does not block issue_en_i internally; gating is the issue logic's job.
- Latency:
  - write visible on read ports the same cycle (BYPASS=1), or from the next cycle (BYPASS=0);
  - pending changes visible the cycle after the edge.
- Reset mid-operation: all pending bits dropped. Writebacks still in flight after reset still write the register file normally.

Test Plan:
- Reset, then read all addresses → rd_data_a_o = rd_data_b_o = 0, pending_o = 0000, stall_o = 0, onehot_err_o = 0.
- wr_onehot_i=0010, wr_data_i=64'hDEAD_BEEF, rd_addr_a_i=1 in the same cycle → rd_data_a_o = DEADBEEF combinationally (BYPASS=1); after the edge with wr_onehot_i=0 → still DEADBEEF.
- Write 64'h5 with wr_onehot_i=1000 (ZERO_REG=3), then read addr 3 → 0; issue_addr_i=3 → pending_o stays 0000.
- issue_en_i=1, issue_addr_i=2; next cycle rd_addr_b_i=2, rd_en_b_i=1 → pending_o=0100 and stall_o=1; same cycle wr_onehot_i=0100, data 7 → stall_o=0, rd_data_b_o=7; after the edge pending_o=0000.
- Same cycle: issue_en_i=1 to reg 0 and wr_onehot_i=0001 with pending_o[0]=1 → pending_o[0] remains 1 and reg 0 takes the write data.
- wr_onehot_i=0011, wr_data_i=9 → no register changes, no bypass, onehot_err_o=1 after the edge and stays 1 until reset_i.
